bbc_host_sram_arbiter: RTL

Two-requester arbiter that shares the single host SRAM port of `bbc_micro_with_rams` between two independent masters, e.g. a ROM/disk loader and a debug memory monitor. It sits in `bbc_project` between the requesters and the `host_sram_request`/`host_sram_response` bundle, replacing the current tie-offs. Grants are round-robin with one transfer per grant. An in-order tag FIFO routes read data back to the requester that issued each read.

---
 rtl/bbc_host_sram_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bbc_host_sram_arbiter.sv
`timescale 1ns/1ps
// bbc_host_sram_arbiter
// Round-robin arbiter sharing the single host SRAM port between two masters.
// One transfer per grant. An in-order tag FIFO steers each read return to
// the requester that issued that read.
module bbc_host_sram_arbiter #(
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_req__valid,
    input  logic        a_req__read_enable,
    input  logic        a_req__write_enable,
    input  logic [7:0]  a_req__select,
    input  logic [23:0] a_req__address,
    input  logic [63:0] a_req__write_data,
    output logic        a_rsp__ack,
    output logic        a_rsp__read_data_valid,
    output logic [63:0] a_rsp__read_data,

    input  logic        b_req__valid,
    input  logic        b_req__read_enable,
    input  logic        b_req__write_enable,
    input  logic [7:0]  b_req__select,
    input  logic [23:0] b_req__address,
    input  logic [63:0] b_req__write_data,
    output logic        b_rsp__ack,
    output logic        b_rsp__read_data_valid,
    output logic [63:0] b_rsp__read_data,

    output logic        host_sram_request__valid,
    output logic        host_sram_request__read_enable,
    output logic        host_sram_request__write_enable,
    output logic [7:0]  host_sram_request__select,
    output logic [23:0] host_sram_request__address,
    output logic [63:0] host_sram_request__write_data,
    input  logic        host_sram_response__ack,
    input  logic        host_sram_response__read_data_valid,
    input  logic [63:0] host_sram_response__read_data,

    output logic        arb_error,
    output logic [4:0]  outstanding_reads
);

    localparam int unsigned PTR_W   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_5 = 5'(TAG_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_A = 2'd1;
    localparam logic [1:0] ST_GRANT_B = 2'd2;

    // Tag values double as the last_grant encoding.
    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    logic [1:0]       state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic [4:0]       count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             tag_mem [TAG_DEPTH];

    logic grant_a, grant_b;
    logic a_eligible, b_eligible;
    logic xfer_done, push, pop, push_tag, head_tag;
    logic fifo_empty, room_for_read;
    logic rd_error, drop_error;

    assign grant_a       = (state == ST_GRANT_A);
    assign grant_b       = (state == ST_GRANT_B);
    assign fifo_empty    = (count == '0);
    assign room_for_read = (count < DEPTH_5);

    assign a_eligible = a_req__valid & (~a_req__read_enable | room_for_read);
    assign b_eligible = b_req__valid & (~b_req__read_enable | room_for_read);

    // Host request: pass the granted requester through, all zero otherwise.
    always_comb begin
        host_sram_request__valid        = 1'b0;
        host_sram_request__read_enable  = 1'b0;
        host_sram_request__write_enable = 1'b0;
        host_sram_request__select       = '0;
        host_sram_request__address      = '0;
        host_sram_request__write_data   = '0;
        if (grant_a) begin
            host_sram_request__valid        = a_req__valid;
            host_sram_request__read_enable  = a_req__read_enable;
            host_sram_request__write_enable = a_req__write_enable;
            host_sram_request__select       = a_req__select;
            host_sram_request__address      = a_req__address;
            host_sram_request__write_data   = a_req__write_data;
        end else if (grant_b) begin
            host_sram_request__valid        = b_req__valid;
            host_sram_request__read_enable  = b_req__read_enable;
            host_sram_request__write_enable = b_req__write_enable;
            host_sram_request__select       = b_req__select;
            host_sram_request__address      = b_req__address;
            host_sram_request__write_data   = b_req__write_data;
        end
    end

    assign xfer_done  = host_sram_request__valid & host_sram_response__ack;
    assign drop_error = (grant_a | grant_b) & ~host_sram_request__valid;
    // Read+write together counts as a read.
    assign push       = xfer_done & host_sram_request__read_enable;
    assign push_tag   = grant_b ? TAG_B : TAG_A;

    assign head_tag = tag_mem[rd_ptr];
    assign pop      = host_sram_response__read_data_valid & ~fifo_empty;
    assign rd_error = host_sram_response__read_data_valid & fifo_empty;

    assign a_rsp__ack             = grant_a & host_sram_response__ack;
    assign b_rsp__ack             = grant_b & host_sram_response__ack;
    assign a_rsp__read_data_valid = pop & (head_tag == TAG_A);
    assign b_rsp__read_data_valid = pop & (head_tag == TAG_B);
    assign a_rsp__read_data       = host_sram_response__read_data;
    assign b_rsp__read_data       = host_sram_response__read_data;
    assign outstanding_reads      = count;

    // Next grant state and round-robin pointer.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            ST_IDLE: begin
                if (a_eligible && b_eligible)
                    state_nxt = (last_grant == TAG_A) ? ST_GRANT_B : ST_GRANT_A;
                else if (a_eligible)
                    state_nxt = ST_GRANT_A;
                else if (b_eligible)
                    state_nxt = ST_GRANT_B;
            end
            ST_GRANT_A, ST_GRANT_B: begin
                if (xfer_done) begin
                    state_nxt      = ST_IDLE;
                    last_grant_nxt = push_tag;
                end else if (drop_error) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control registers: grant state, fairness bit, FIFO pointers, sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= TAG_B;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            arb_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (rd_error || drop_error)
                arb_error <= 1'b1;
        end
    end

    // Tag storage; contents are meaningless outside the valid window.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= push_tag;
    end

endmodule
